nibble_serial_add_ctrl: RTL and testbench

Multi-cycle sequencer that performs wide add/subtract by time-sharing exactly one instance of the team's 4-bit ripple-carry adder (`adder`). Per clock it processes one nibble, LSB first, and carries between nibbles in a register. It gives narrow-area datapaths a 4*NIBBLES-bit add/sub behind a start/busy/done handshake.

---
 rtl/nibble_serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// 4-bit ripple-carry adder, then a W-bit add/sub that reuses it one nibble per clock, LSB first.
// Latency NIBBLES+1 cycles from start to done; start is ignored, not queued, while busy.
module adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[4];
endmodule

module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 overflow
);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [NIBBLES-1:0][3:0] a_q, b_q, res_q;
  logic [IW-1:0]           idx;
  logic                    cy_q;
  logic                    accept;
  logic                    last;
  logic [3:0]              sum;
  logic                    cout;

  adder u_adder (
    .a    (a_q[idx]),
    .b    (b_q[idx]),
    .cin  (cy_q),
    .sum  (sum),
    .cout (cout)
  );

  assign last   = (state == RUN) && (idx == LAST);
  assign result = res_q;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        // back-to-back start is accepted straight out of DONE
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      idx       <= '0;
      cy_q      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q   <= op_a;
        b_q   <= sub ? ~op_b : op_b;
        cy_q  <= sub;
        idx   <= '0;
        res_q <= '0;
      end else if (state == RUN) begin
        res_q[idx] <= sum;
        cy_q       <= cout;
        if (last) begin
          carry_out <= cout;
          // signed overflow: like-signed operands giving an opposite-signed result
          overflow  <= (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                       (sum[3] != a_q[NIBBLES-1][3]);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench: expectations queued at start, compared on each done pulse.
module tb_nibble_serial_add_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, sub = 1'b0;
  logic [15:0] op_a = '0, op_b = '0;
  logic        busy, done, carry_out, overflow;
  logic [15:0] result;

  logic        start1 = 1'b0, sub1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0, result1;
  logic        busy1, done1, co1, ov1;

  logic        start2 = 1'b0, sub2 = 1'b0;
  logic [7:0]  a2 = '0, b2 = '0, result2;
  logic        busy2, done2, co2, ov2;

  typedef struct {
    logic [15:0] r;
    logic        co;
    logic        ov;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   push_cnt = 0;

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  nibble_serial_add_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .op_a(a1), .op_b(b1),
    .busy(busy1), .done(done1), .result(result1), .carry_out(co1), .overflow(ov1)
  );

  nibble_serial_add_ctrl #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .op_a(a2), .op_b(b2),
    .busy(busy2), .done(done2), .result(result2), .carry_out(co2), .overflow(ov2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                 input int due);
    exp_t        e;
    logic [15:0] bb;
    logic [16:0] full;
    bb    = s ? ~b : b;
    full  = {1'b0, a} + {1'b0, bb} + {16'b0, s};
    e.r   = full[15:0];
    e.co  = full[16];
    e.ov  = (a[15] == bb[15]) && (full[15] != a[15]);
    e.due = due;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      if (q.size() == 0) begin
        check_val("spurious_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check_val("result", {16'b0, result}, {16'b0, e.r});
        check_val("carry_out", {31'b0, carry_out}, {31'b0, e.co});
        check_val("overflow", {31'b0, overflow}, {31'b0, e.ov});
        check_val("done_cycle", cyc, e.due);
        check_val("busy_in_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 20) begin
      check_val("busy_run", {31'b0, busy}, 32'd1);
      n++;
      @(negedge clk);
    end
    if (!done) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [15:0] er, input logic eco, input logic eov);
    exp_t e;
    @(posedge clk); #1;
    op_a = a; op_b = b; sub = s; start = 1'b1;
    e.r = er; e.co = eco; e.ov = eov; e.due = cyc + 1 + 4;
    q.push_back(e);
    push_cnt++;
    @(posedge clk); #1;
    start = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom); sub = ~s;
    wait_done();
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check_val("drain_timeout", q.size(), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [15:0] ra, rb;
    logic        rs;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_done", {31'b0, done}, 32'd0);
    check_val("rst_result", {16'b0, result}, 32'd0);
    check_val("rst_carry", {31'b0, carry_out}, 32'd0);
    check_val("rst_ovf", {31'b0, overflow}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_val("hold_result", {16'b0, result}, 32'h7FFF);
    check_val("hold_ovf", {31'b0, overflow}, 32'd1);

    // ignored start during RUN, then back-to-back start in the DONE cycle
    @(posedge clk); #1;
    op_a = 16'h4321; op_b = 16'h1234; sub = 1'b1; start = 1'b1;
    e.r = 16'h30ED; e.co = 1'b1; e.ov = 1'b0; e.due = cyc + 5;
    q.push_back(e); push_cnt++;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    op_a = 16'h0F0F; op_b = 16'hF0F1; sub = 1'b0; start = 1'b1;
    e.r = 16'h0000; e.co = 1'b1; e.ov = 1'b0; e.due = cyc + 5;
    q.push_back(e); push_cnt++;
    @(posedge clk); #1; start = 1'b0;
    drain();

    // reset while RUN is at nibble 2: operation abandoned
    @(posedge clk); #1;
    op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check_val("mrst_busy", {31'b0, busy}, 32'd0);
    check_val("mrst_done", {31'b0, done}, 32'd0);
    check_val("mrst_result", {16'b0, result}, 32'd0);
    check_val("mrst_carry", {31'b0, carry_out}, 32'd0);
    check_val("mrst_ovf", {31'b0, overflow}, 32'd0);
    repeat (8) @(negedge clk);
    run_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      if (i == 0) begin ra = 16'h8000; rb = 16'h8000; rs = 1'b0; end
      if (i == 1) begin ra = 16'h0000; rb = 16'h0000; rs = 1'b1; end
      e = model(ra, rb, rs, 0);
      run_op(ra, rb, rs, e.r, e.co, e.ov);
    end
    drain();

    // NIBBLES=1: 0xF + 0x1
    @(posedge clk); #1;
    a1 = 4'hF; b1 = 4'h1; sub1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    @(negedge clk);
    check_val("n1_busy", {31'b0, busy1}, 32'd1);
    check_val("n1_done_early", {31'b0, done1}, 32'd0);
    @(negedge clk);
    check_val("n1_done", {31'b0, done1}, 32'd1);
    check_val("n1_result", {28'b0, result1}, 32'h0);
    check_val("n1_carry", {31'b0, co1}, 32'd1);
    check_val("n1_ovf", {31'b0, ov1}, 32'd0);

    // NIBBLES=2: 0x80 - 0x01
    @(posedge clk); #1;
    a2 = 8'h80; b2 = 8'h01; sub2 = 1'b1; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    @(negedge clk);
    check_val("n2_busy0", {31'b0, busy2}, 32'd1);
    @(negedge clk);
    check_val("n2_busy1", {31'b0, busy2}, 32'd1);
    @(negedge clk);
    check_val("n2_done", {31'b0, done2}, 32'd1);
    check_val("n2_result", {24'b0, result2}, 32'h7F);
    check_val("n2_carry", {31'b0, co2}, 32'd1);
    check_val("n2_ovf", {31'b0, ov2}, 32'd1);

    repeat (3) @(negedge clk);
    check_val("done_count", done_cnt, push_cnt);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
